// File: rtl/sample_pkg.sv
// Shared sizing defaults and pointer/count width helpers for the sample FIFO.
package sample_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEPTH = 16;

   function automatic int ptr_bits(input int entries);
      return $clog2(entries);
   endfunction

   // One extra bit so a completely full FIFO is distinguishable from an empty one
   function automatic int count_bits(input int entries);
      return $clog2(entries) + 1;
   endfunction

endpackage

// File: rtl/sample_fifo_mem.sv
// Sample storage array: synchronous write, asynchronous read, no reset on contents.
module sample_fifo_mem
   import sample_pkg::*;
#(
   parameter int width = DEFAULT_WIDTH,
   parameter int depth = DEFAULT_DEPTH,
   localparam int PTR_W = ptr_bits(depth)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [PTR_W-1:0] wr_addr,
   input  logic [width-1:0] wr_data,
   input  logic [PTR_W-1:0] rd_addr,
   output logic [width-1:0] rd_data
);

   logic [width-1:0] mem [depth];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sample_fifo.sv
// Show-ahead sample FIFO with registered head output.
// Optional sticky overflow/underflow outputs are enabled with macro SAMPLE_FIFO_STATUS_EN.
module sample_fifo
   import sample_pkg::*;
#(
   parameter int width = DEFAULT_WIDTH,
   parameter int depth = DEFAULT_DEPTH,
   localparam int PTR_W = ptr_bits(depth),
   localparam int CNT_W = count_bits(depth)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic [width-1:0] wr_data,
   input  logic             wr_valid,
   output logic             wr_ready,
   output logic [width-1:0] rd_data,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [CNT_W-1:0] count
`ifdef SAMPLE_FIFO_STATUS_EN
   ,
   output logic             overflow,
   output logic             underflow
`endif
);

   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(depth);

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] rd_ptr_next;
   logic [CNT_W-1:0] count_next;
   logic [width-1:0] mem_head;
   logic [width-1:0] head_next;
   logic             wr_en;
   logic             rd_en;

   assign wr_ready = (count != FULL_COUNT);
   assign rd_valid = (count != '0);
   assign wr_en    = wr_valid && wr_ready && !flush;
   assign rd_en    = rd_valid && rd_ready && !flush;

   sample_fifo_mem #(
      .width (width),
      .depth (depth)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (wr_data),
      .rd_addr (rd_ptr_next),
      .rd_data (mem_head)
   );

   always_comb begin
      rd_ptr_next = rd_ptr;
      if (rd_en) begin
         rd_ptr_next = rd_ptr + PTR_W'(1);
      end
   end

   always_comb begin
      count_next = count;
      case ({wr_en, rd_en})
         2'b10:   count_next = count + CNT_W'(1);
         2'b01:   count_next = count - CNT_W'(1);
         default: count_next = count;
      endcase
   end

   // The head register is loaded with whatever entry will be at the front after this
   // edge; when that slot is the one being written right now the array still holds
   // stale data, so the incoming word is taken instead.
   always_comb begin
      head_next = rd_data;
      if (!flush && count_next != '0) begin
         if (wr_en && rd_ptr_next == wr_ptr) begin
            head_next = wr_data;
         end else begin
            head_next = mem_head;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         rd_data <= '0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         rd_ptr  <= rd_ptr_next;
         count   <= count_next;
         rd_data <= head_next;
      end
   end

`ifdef SAMPLE_FIFO_STATUS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_valid && !wr_ready) begin
            overflow <= 1'b1;
         end
         if (rd_ready && !rd_valid) begin
            underflow <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_sample_fifo.sv
// Scoreboard bench for sample_fifo; flag checks follow SAMPLE_FIFO_STATUS_EN.
module tb_sample_fifo;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;

   logic       clk;
   logic       reset_n;
   logic       flush;
   logic [7:0] wr_data;
   logic       wr_valid;
   logic       wr_ready;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       rd_ready;
   logic [4:0] count;
`ifdef SAMPLE_FIFO_STATUS_EN
   logic       overflow;
   logic       underflow;
`endif

   int         compared;
   int         mismatched;
   logic [7:0] sb [$];
   int         model_count;
   logic [7:0] last_head;
   logic       model_ovf;
   logic       model_unf;

   sample_fifo #(
      .width (WIDTH),
      .depth (DEPTH)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .flush    (flush),
      .wr_data  (wr_data),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .rd_ready (rd_ready),
      .count    (count)
`ifdef SAMPLE_FIFO_STATUS_EN
      ,
      .overflow  (overflow),
      .underflow (underflow)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic resetModel();
      sb.delete();
      model_count = 0;
      last_head   = 8'h00;
      model_ovf   = 1'b0;
      model_unf   = 1'b0;
   endtask

   task automatic checkState(input string tag);
      checkOutput({tag, ".count"}, 32'(count), 32'(model_count));
      checkOutput({tag, ".wr_ready"}, 32'(wr_ready), 32'(model_count != DEPTH));
      checkOutput({tag, ".rd_valid"}, 32'(rd_valid), 32'(model_count != 0));
      if (model_count != 0) begin
         last_head = sb[0];
      end
      checkOutput({tag, ".head"}, 32'(rd_data), 32'(last_head));
`ifdef SAMPLE_FIFO_STATUS_EN
      checkOutput({tag, ".overflow"}, 32'(overflow), 32'(model_ovf));
      checkOutput({tag, ".underflow"}, 32'(underflow), 32'(model_unf));
`endif
   endtask

   // Drive one cycle from just after a falling edge, score it, then check after the rising edge
   task automatic applyStimulus(input logic f, input logic wv, input logic [7:0] wd, input logic rr);
      logic       wr_acc;
      logic       rd_acc;
      logic [7:0] exp_data;
      flush    = f;
      wr_valid = wv;
      wr_data  = wd;
      rd_ready = rr;
      #1;
      wr_acc = !f && wv && (model_count != DEPTH);
      rd_acc = !f && rr && (model_count != 0);
      if (rd_acc) begin
         exp_data = sb.pop_front();
         checkOutput("rd_data", 32'(rd_data), 32'(exp_data));
      end
      if (f) begin
         sb.delete();
         model_count = 0;
         model_ovf   = 1'b0;
         model_unf   = 1'b0;
      end else begin
         if (wr_acc) begin
            sb.push_back(wd);
         end
         model_count = model_count + (wr_acc ? 1 : 0) - (rd_acc ? 1 : 0);
         if (wv && model_count == DEPTH && !wr_acc && !rd_acc) begin
            model_ovf = 1'b1;
         end
         if (wv && !wr_acc) begin
            model_ovf = 1'b1;
         end
         if (rr && !rd_acc) begin
            model_unf = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      checkState("cycle");
      @(negedge clk);
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      resetModel();
      reset_n  = 1'b0;
      flush    = 1'b0;
      wr_valid = 1'b0;
      wr_data  = 8'h00;
      rd_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkState("reset");
      @(negedge clk);
      reset_n = 1'b1;

      applyStimulus(1'b0, 1'b1, 8'h11, 1'b0);
      checkOutput("first_visible", 32'(rd_data), 32'h11);
      applyStimulus(1'b0, 1'b1, 8'h22, 1'b0);
      applyStimulus(1'b0, 1'b1, 8'h33, 1'b0);
      checkOutput("three_written", 32'(count), 32'd3);

      for (int i = 3; i < DEPTH; i++) begin
         applyStimulus(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
      end
      checkOutput("full_ready", 32'(wr_ready), 32'd0);
      applyStimulus(1'b0, 1'b1, 8'hEE, 1'b0);
      checkOutput("overfill_count", 32'(count), 32'd16);

      applyStimulus(1'b0, 1'b1, 8'hDD, 1'b1);
      checkOutput("full_rw_count", 32'(count), 32'd15);
      checkOutput("full_rw_ready", 32'(wr_ready), 32'd1);

      for (int i = 0; i < 15; i++) begin
         applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      end
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checkOutput("empty_read_count", 32'(count), 32'd0);

      applyStimulus(1'b0, 1'b1, 8'hAA, 1'b0);
      for (int i = 0; i < 40; i++) begin
         applyStimulus(1'b0, 1'b1, 8'(i), 1'b1);
      end
      checkOutput("stream_count", 32'(count), 32'd1);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)),
                       8'($urandom), 1'($urandom_range(0, 1)));
      end

      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b1, 8'(8'h60 + i), 1'b0);
      end
      applyStimulus(1'b1, 1'b1, 8'h99, 1'b1);
      checkOutput("flush_count", 32'(count), 32'd0);

      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b1, 8'(8'h70 + i), 1'b0);
      end
      flush    = 1'b0;
      wr_valid = 1'b1;
      wr_data  = 8'h55;
      rd_ready = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      resetModel();
      checkState("async_reset");
      @(negedge clk);
      wr_valid = 1'b0;
      reset_n  = 1'b1;

      applyStimulus(1'b0, 1'b1, 8'hC1, 1'b0);
      applyStimulus(1'b0, 1'b1, 8'hC2, 1'b1);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
